dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of datamemory.
- Port A is the CPU load/store path; port B is a secondary master (debug loader / DMA).
- Latches one request per transaction, drives MemRead/MemWrite/address/Funct3/write data for exactly one access cycle, and returns registered read data to the winning requester.
- Sits between the MEM stage / secondary master and the datamemory instance.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                               |
// | Description : Two-port round-robin arbiter and single-access sequencer   |
// |               in front of datamemory. Port A = CPU, port B = secondary.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // Port A (CPU load/store path)
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DM_ADDRESS-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wd,
  input  logic [2:0]            a_funct3,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  // Port B (debug loader / DMA)
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [DM_ADDRESS-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wd,
  input  logic [2:0]            b_funct3,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  // datamemory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // Owner / last-winner encoding: 0 = port A, 1 = port B.
  localparam logic c_PORT_A = 1'b0;
  localparam logic c_PORT_B = 1'b1;

  state_t                r_state;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wd;
  logic [2:0]            r_funct3;
  logic                  r_a_gnt;
  logic                  r_b_gnt;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [DATA_W-1:0]     r_a_rdata;
  logic [DATA_W-1:0]     r_b_rdata;

  logic                  w_any_req;
  logic                  w_sel_b;

  // Round-robin pick: a lone requester wins; on a tie the port that did not win last time wins.
  assign w_any_req = a_req | b_req;
  assign w_sel_b   = b_req & (~a_req | (r_last == c_PORT_A));

  // Single sequencer: latch a request in IDLE, run one ACCESS cycle, capture load data on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last     <= c_PORT_B;
      r_owner    <= c_PORT_A;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_funct3   <= 3'b000;
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner  <= w_sel_b;
            r_last   <= w_sel_b;
            r_we     <= w_sel_b ? b_we     : a_we;
            r_addr   <= w_sel_b ? b_addr   : a_addr;
            r_wd     <= w_sel_b ? b_wd     : a_wd;
            r_funct3 <= w_sel_b ? b_funct3 : a_funct3;
            r_a_gnt  <= ~w_sel_b;
            r_b_gnt  <= w_sel_b;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Requests still high here are ignored; arbitration resumes next cycle.
          if (!r_we) begin
            if (r_owner == c_PORT_B) begin
              r_b_rdata  <= mem_rd;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= mem_rd;
              r_a_rvalid <= 1'b1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state so a reset mid-access drops them at once.
  assign mem_read   = (r_state == S_ACCESS) & ~r_we;
  assign mem_write  = (r_state == S_ACCESS) &  r_we;
  assign mem_a      = r_addr;
  assign mem_wd     = r_wd;
  assign mem_funct3 = r_funct3;

  assign a_gnt      = r_a_gnt;
  assign b_gnt      = r_b_gnt;
  assign a_rvalid   = r_a_rvalid;
  assign b_rvalid   = r_b_rvalid;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                            |
// | Description : Directed self-checking bench for dmem_arbiter.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  a_req, a_we, b_req, b_we;
  logic [DM_ADDRESS-1:0] a_addr, b_addr;
  logic [DATA_W-1:0]     a_wd, b_wd;
  logic [2:0]            a_funct3, b_funct3;
  logic                  a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0]     a_rdata, b_rdata;
  logic                  mem_read, mem_write;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rd;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd), .a_funct3(a_funct3),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd), .b_funct3(b_funct3),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to the next falling edge: outputs are stable there and inputs are driven there.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wd = '0; a_funct3 = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wd = '0; b_funct3 = '0;
    mem_rd = '0;
    tick(); tick();
    // {a_gnt,b_gnt,a_rvalid,b_rvalid,mem_read,mem_write}
    check("rst_ctrl", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write}, 64'h0);
    check("rst_data", {a_rdata, b_rdata}, 64'h0);
    check("rst_mem", {mem_a, mem_wd, mem_funct3}, 64'h0);
    reset = 1'b0;

    // ---- A load ----
    a_req = 1; a_we = 0; a_addr = 9'h010; a_funct3 = 3'b010;
    tick();
    check("ldA_gnt", {a_gnt, b_gnt}, 64'b10);
    check("ldA_strobe", {mem_read, mem_write}, 64'b10);
    check("ldA_addr", {mem_a, mem_funct3}, {9'h010, 3'b010});
    mem_rd = 32'hDEADBEEF; a_req = 0;
    tick();
    check("ldA_rvalid", {a_rvalid, b_rvalid, a_gnt, b_gnt, mem_read}, 64'b10000);
    check("ldA_rdata", a_rdata, 64'hDEADBEEF);
    check("ldA_b_rdata", b_rdata, 64'h0);
    tick();
    check("ldA_rvalid_drop", a_rvalid, 64'h0);

    // ---- B store ----
    b_req = 1; b_we = 1; b_addr = 9'h1F0; b_wd = 32'h12345678; b_funct3 = 3'b000;
    tick();
    check("stB_gnt", {a_gnt, b_gnt}, 64'b01);
    check("stB_strobe", {mem_read, mem_write}, 64'b01);
    check("stB_fields", {mem_a, mem_wd, mem_funct3}, {9'h1F0, 32'h12345678, 3'b000});
    b_req = 0; b_we = 0; mem_rd = 32'hFFFF0000;
    tick();
    check("stB_after", {b_gnt, b_rvalid, a_rvalid, mem_write}, 64'h0);
    check("stB_b_rdata", b_rdata, 64'h0);

    // ---- fairness, both held, right after reset ----
    reset = 1'b1; tick(); reset = 1'b0;
    a_req = 1; a_we = 0; a_addr = 9'h020; a_funct3 = 3'b010;
    b_req = 1; b_we = 0; b_addr = 9'h040; b_funct3 = 3'b001;
    for (int i = 0; i < 8; i++) begin
      logic is_b;
      is_b = i[0];
      tick();
      check($sformatf("rr_gnt%0d", i), {a_gnt, b_gnt}, is_b ? 64'b01 : 64'b10);
      check($sformatf("rr_addr%0d", i), mem_a, is_b ? 64'h040 : 64'h020);
      mem_rd = 32'h1000 + i;
      if (i == 6) a_req = 0;
      if (i == 7) b_req = 0;
      tick();
      check($sformatf("rr_idle%0d", i), {a_gnt, b_gnt, a_rvalid, b_rvalid},
            is_b ? 64'b0001 : 64'b0010);
      check($sformatf("rr_rdata%0d", i), is_b ? b_rdata : a_rdata, 64'h1000 + i);
    end

    // ---- B load then A load: B data must persist ----
    b_req = 1; b_we = 0; b_addr = 9'h0AA;
    tick();
    check("hold_bgnt", {a_gnt, b_gnt}, 64'b01);
    mem_rd = 32'h0000AAAA; b_req = 0;
    tick();
    check("hold_bload", b_rdata, 64'h0000AAAA);
    a_req = 1; a_we = 0; a_addr = 9'h055;
    tick();
    check("hold_agnt", {a_gnt, b_gnt}, 64'b10);
    mem_rd = 32'h00005555; a_req = 0;
    tick();
    check("hold_aload", a_rdata, 64'h00005555);
    check("hold_bkeep", b_rdata, 64'h0000AAAA);

    // ---- reset during an A store ACCESS (last winner is A here) ----
    a_req = 1; a_we = 1; a_addr = 9'h030; a_wd = 32'hCAFEF00D; a_funct3 = 3'b010;
    tick();
    check("rstacc_wr", {mem_write, a_gnt}, 64'b11);
    #1 reset = 1'b1;
    #1;
    check("rstacc_drop", {mem_write, mem_read, a_gnt}, 64'h0);
    a_req = 0; a_we = 0;
    tick(); reset = 1'b0;
    tick();
    check("rstacc_nognt", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 64'h0);
    a_req = 1; b_req = 1; b_we = 0; a_addr = 9'h011; b_addr = 9'h022;
    tick();
    check("rstacc_apri", {a_gnt, b_gnt}, 64'b10);
    a_req = 0;
    tick();
    tick();
    check("rstacc_bnext", {a_gnt, b_gnt}, 64'b01);
    b_req = 0;
    tick();

    // ---- idle period ----
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle%0d", i),
            {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write}, 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
